gray_decode_checker: RTL

//  Downstream consumer of gray_counter: samples its gray-coded output, converts it to binary,
//  and checks the Gray property (exactly one bit changes per forward step, mod 2^WIDTH).

---
 rtl/gray_decode_checker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/gray_decode_checker.sv
// -----------------------------------------------------------------------------
// gray_decode_checker
//
// Purpose:
//   Samples the gray-coded output of an upstream gray counter, converts it to
//   binary and checks that every accepted step is a single forward Gray step
//   (mod 2^WIDTH). Illegal steps are flagged and counted with a saturating
//   counter. Wrap-around from all-ones to zero is pulsed. A small two-state
//   FSM (ACQUIRE / TRACK) locks onto the stream. Two consecutive illegal
//   steps drop the lock so the next sample re-acquires.
//
// Parameters:
//   WIDTH      gray/binary word width (>= 2)
//   ERR_CNT_W  width of the saturating error counter (>= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low (0 = reset)
//   gray_in    in   gray code from the upstream counter
//   valid_in   in   gray_in is sampled on this cycle
//   bin_out    out  registered binary value of the last accepted sample
//   bin_valid  out  1-cycle pulse: bin_out was updated
//   wrap       out  1-cycle pulse: legal step from all-ones to zero
//   step_err   out  1-cycle pulse: illegal step detected
//   err_count  out  number of step_err pulses, saturating at all-ones
//   locked     out  1 while the FSM is in TRACK
//
// Configuration:
//   GRAY_SYNC_EN  when defined, gray_in and valid_in pass through a 2-flop
//                 synchronizer (reset to 0) before the checker. Latency from
//                 an input change to the outputs becomes 3 cycles instead
//                 of 1. The port list is the same in both builds.
// -----------------------------------------------------------------------------
module gray_decode_checker #(
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 valid_in,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 bin_valid,
   output logic                 wrap,
   output logic                 step_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 locked
);

   typedef enum logic {
      ACQUIRE = 1'b0,
      TRACK   = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0]     BIN_ONE = WIDTH'(1);
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

   state_t           state;
   logic [WIDTH-1:0] ref_bin;     // binary value of the last accepted sample
   logic             consec_err;  // previous accepted non-hold step was an error

   logic [WIDTH-1:0] chk_gray;
   logic             chk_valid;

`ifdef GRAY_SYNC_EN
   logic [WIDTH-1:0] gray_s1, gray_s2;
   logic             valid_s1, valid_s2;

   // Gray data is safe to synchronize bit-wise because the upstream counter
   // changes only one bit per step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gray_s1  <= '0;
         gray_s2  <= '0;
         valid_s1 <= 1'b0;
         valid_s2 <= 1'b0;
      end else begin
         gray_s1  <= gray_in;
         gray_s2  <= gray_s1;
         valid_s1 <= valid_in;
         valid_s2 <= valid_s1;
      end
   end

   assign chk_gray  = gray_s2;
   assign chk_valid = valid_s2;
`else
   assign chk_gray  = gray_in;
   assign chk_valid = valid_in;
`endif

   // Binary bit i is the XOR of all gray bits from the MSB down to i.
   logic [WIDTH-1:0] sample_bin;
   always_comb begin
      // NOTE: default first so every path assigns sample_bin and no latch is inferred.
      sample_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sample_bin[i] = ^(chk_gray >> i);
      end
   end

   // Compare in the gray domain for the hamming distance and in the binary
   // domain for direction; a backward single-bit step fails the direction test.
   logic [WIDTH-1:0] ref_gray;
   logic             same_sample;
   logic             legal_step;

   assign ref_gray    = ref_bin ^ (ref_bin >> 1);
   assign same_sample = (chk_gray == ref_gray);
   assign legal_step  = $onehot(chk_gray ^ ref_gray) && (sample_bin == ref_bin + BIN_ONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ACQUIRE;
         ref_bin    <= '0;
         consec_err <= 1'b0;
         bin_out    <= '0;
         bin_valid  <= 1'b0;
         wrap       <= 1'b0;
         step_err   <= 1'b0;
         err_count  <= '0;
      end else begin
         // NOTE: non-blocking assignments only here; later reads in this block see the old register values.
         bin_valid <= 1'b0;
         wrap      <= 1'b0;
         step_err  <= 1'b0;

         if (chk_valid) begin
            unique case (state)
               ACQUIRE: begin
                  ref_bin    <= sample_bin;
                  bin_out    <= sample_bin;
                  bin_valid  <= 1'b1;
                  consec_err <= 1'b0;
                  state      <= TRACK;
               end

               TRACK: begin
                  if (legal_step) begin
                     ref_bin    <= sample_bin;
                     bin_out    <= sample_bin;
                     bin_valid  <= 1'b1;
                     wrap       <= (ref_bin == '1);
                     consec_err <= 1'b0;
                  end else if (!same_sample) begin
                     // Resync to the offending sample so a single glitch
                     // costs one error rather than a cascade.
                     ref_bin   <= sample_bin;
                     bin_out   <= sample_bin;
                     bin_valid <= 1'b1;
                     step_err  <= 1'b1;
                     if (err_count != '1) begin
                        err_count <= err_count + CNT_ONE;
                     end
                     if (consec_err) begin
                        state      <= ACQUIRE;
                        consec_err <= 1'b0;
                     end else begin
                        consec_err <= 1'b1;
                     end
                  end
               end

               default: state <= ACQUIRE;
            endcase
         end
      end
   end

   // state is itself a flop, so locked is a registered output.
   assign locked = (state == TRACK);

endmodule
